// File: rtl/mil_bc_seq.sv
// MIL-STD-1553 bus controller message sequencer for BC-to-RT transfers.
// Sends a command word and its data words on a fixed slot grid, then waits
// for the RT status word, a timeout, or a wrong-sync reply, and finally
// holds an inter-message gap before accepting the next start.
module mil_bc_seq #(
    parameter int WORD_CLKS = 1000,
    parameter int RESP_TMO  = 700,
    parameter int GAP_CLKS  = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] cmd_word,
    output logic        dat_req,
    input  logic [15:0] dat_in,
    output logic        txen,
    output logic [15:0] dat,
    output logic        cw_dw,
    input  logic        ok_rx,
    input  logic [15:0] rx_dat,
    input  logic        rx_cw,
    output logic        busy,
    output logic        done,
    output logic        tmo,
    output logic        sync_err,
    output logic [15:0] status_word
);

    localparam int SW = $clog2(WORD_CLKS + 1);
    localparam int TW = $clog2(RESP_TMO + 1);
    localparam int GW = $clog2(GAP_CLKS + 1);

    // dat_req is registered, so it is raised one count early to be high at WORD_CLKS-3
    localparam logic [SW-1:0] SLOT_REQ  = SW'(WORD_CLKS - 4);
    localparam logic [SW-1:0] SLOT_LAT  = SW'(WORD_CLKS - 2);
    localparam logic [SW-1:0] SLOT_LAST = SW'(WORD_CLKS - 1);
    // The edge that moves the timer onto RESP_TMO is the timeout edge
    localparam logic [TW-1:0] TMO_LAST  = TW'(RESP_TMO - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CLKS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StTxCw,
        StTxDw,
        StWaitSw,
        StGap
    } state_t;

    state_t        state;
    logic [SW-1:0] slot;
    logic [TW-1:0] timer;
    logic [GW-1:0] gap;
    logic [5:0]    rem;
    logic [15:0]   dbuf;

    // Message sequencer: state, counters and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            slot        <= '0;
            timer       <= '0;
            gap         <= '0;
            rem         <= '0;
            dbuf        <= '0;
            txen        <= 1'b0;
            dat_req     <= 1'b0;
            dat         <= '0;
            cw_dw       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tmo         <= 1'b0;
            sync_err    <= 1'b0;
            status_word <= '0;
        end else begin
            txen     <= 1'b0;
            dat_req  <= 1'b0;
            done     <= 1'b0;
            tmo      <= 1'b0;
            sync_err <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        state <= StTxCw;
                        // A word count field of zero means 32 words
                        rem   <= (cmd_word[4:0] == 5'd0) ? 6'd32 : {1'b0, cmd_word[4:0]};
                        txen  <= 1'b1;
                        dat   <= cmd_word;
                        cw_dw <= 1'b1;
                        slot  <= '0;
                        busy  <= 1'b1;
                    end
                end
                // Receiver strobes here are our own echo and are ignored
                StTxCw, StTxDw: begin
                    if (slot == SLOT_REQ && rem != 6'd0) begin
                        dat_req <= 1'b1;
                    end
                    if (slot == SLOT_LAT) begin
                        dbuf <= dat_in;
                    end
                    if (slot == SLOT_LAST) begin
                        slot <= '0;
                        if (rem != 6'd0) begin
                            state <= StTxDw;
                            txen  <= 1'b1;
                            dat   <= dbuf;
                            cw_dw <= 1'b0;
                            rem   <= rem - 6'd1;
                        end else begin
                            state <= StWaitSw;
                            timer <= '0;
                        end
                    end else begin
                        slot <= slot + SW'(1);
                    end
                end
                // A reply on the timeout edge still counts as a reply
                StWaitSw: begin
                    if (ok_rx) begin
                        done  <= 1'b1;
                        state <= StGap;
                        gap   <= '0;
                        if (rx_cw) begin
                            status_word <= rx_dat;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end else if (timer == TMO_LAST) begin
                        done  <= 1'b1;
                        tmo   <= 1'b1;
                        state <= StGap;
                        gap   <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                StGap: begin
                    if (gap == GAP_LAST) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        gap <= gap + GW'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
